// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states, word geometry,
// the response bundle and an address alignment helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  // A request address is usable only when it names a whole 32-bit word.
  function automatic logic addr_is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/byte_en_word_ram.sv
// Single-port word RAM with per-byte write enables. A read in the same cycle
// as a write returns the old contents (read-first); the read register holds
// its value until the next enabled access.
module byte_en_word_ram
  import mem_pkg::*;
#(
  parameter int NUM_WORDS = 512,
  parameter int AW        = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [WORD_BYTES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [NUM_WORDS];

  // Registered read of the old word, then byte-lane writes on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the processor dmem port. One request at a time is
// accepted, the RAM is read (and optionally written) on the accept edge, and
// the response is presented LATENCY cycles later until the requester takes it.
//
// Handshake: a transfer happens on a posedge where valid && ready are both 1.
// The request side only offers ready while idle; the response side holds
// valid, rdata and err stable until ready is seen, and drives rdata/err to 0
// whenever valid is low.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int NUM_WORDS = 512,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output state_t      dbg_state
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  // One bit wider than the address so the limit itself cannot overflow.
  localparam logic [32:0] ADDR_LIMIT = 33'(NUM_WORDS) * 33'd4;

  state_t      state;
  state_t      next_state;
  logic [CW-1:0] cnt;
  logic        err_q;
  logic        accept;
  logic        req_err;
  logic [31:0] ram_rdata;
  resp_t       resp;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign req_err   = !addr_is_aligned(req_addr) || ({1'b0, req_addr} >= ADDR_LIMIT);
  assign dbg_state = state;

  // Erroneous requests never touch storage.
  byte_en_word_ram #(
    .NUM_WORDS (NUM_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (accept && !req_err),
    .we    (req_wstrb),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept -> wait out the latency -> present until taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latency counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CW'(LATENCY - 1);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Error flag captured at accept and held for the life of the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= req_err;
    end
  end

  // Response outputs: zero unless presenting; errors report zero data.
  always_comb begin
    resp       = '0;
    resp_valid = (state == RESP);
    if (resp_valid) begin
      resp.err   = err_q;
      resp.rdata = err_q ? 32'd0 : ram_rdata;
    end
    resp_rdata = resp.rdata;
    resp_err   = resp.err;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized
// traffic against a word-array model of the storage, with a second instance
// at LATENCY=1 for back-to-back timing.
module tb_dmem_responder;
  import mem_pkg::*;

  localparam int NW  = 512;
  localparam int LAT = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (LATENCY=2)
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  state_t      dbg_state;

  dmem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .dbg_state  (dbg_state)
  );

  // Second instance (LATENCY=1)
  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [31:0] req_addr1 = '0;
  logic [31:0] req_wdata1 = '0;
  logic [3:0]  req_wstrb1 = '0;
  logic        resp_valid1;
  logic        resp_ready1 = 1'b1;
  logic [31:0] resp_rdata1;
  logic        resp_err1;
  state_t      dbg_state1;

  dmem_responder #(.NUM_WORDS(NW), .LATENCY(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_addr   (req_addr1),
    .req_wdata  (req_wdata1),
    .req_wstrb  (req_wstrb1),
    .resp_valid (resp_valid1),
    .resp_ready (resp_ready1),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err1),
    .dbg_state  (dbg_state1)
  );

  // Scoreboard counters and check
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference storage: word contents plus which bytes have ever been written
  logic [31:0] model_mem   [NW];
  logic [3:0]  model_known [NW];

  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // Driver: one full transaction on the main instance, holding the response
  // for `hold` cycles of backpressure before taking it.
  task automatic transact(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int hold,
                          output logic [31:0] got_rdata, output logic got_err);
    int          waited;
    int          lat;
    int          idx;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] mask;
    logic [31:0] held_rdata;
    logic        held_err;

    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);

    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;

    exp_err   = (addr[1:0] != 2'b00) || (addr >= 32'(NW * 4));
    idx       = int'((addr >> 2) & 32'(NW - 1));
    exp_rdata = exp_err ? 32'd0 : model_mem[idx];
    mask      = exp_err ? 32'hFFFF_FFFF : lane_mask(model_known[idx]);
    if (!exp_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
          model_known[idx][i]      = 1'b1;
        end
      end
    end

    @(posedge clk);
    #1;
    // Scribble on the request bus: it must be ignored outside IDLE.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);

    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(LAT));
    got_rdata  = resp_rdata;
    got_err    = resp_err;
    held_rdata = resp_rdata;
    held_err   = resp_err;
    check_eq("resp_err", 32'(resp_err), 32'(exp_err));
    check_eq("resp_rdata", resp_rdata & mask, exp_rdata & mask);

    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", 32'(resp_valid), 32'd1);
      check_eq("bp_rdata", resp_rdata, held_rdata);
      check_eq("bp_err", 32'(resp_err), 32'(held_err));
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check_eq("post_valid", 32'(resp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
    check_eq("post_rdata_zero", resp_rdata, 32'd0);
  endtask

  // Watchdog
  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Main sequence
  initial begin
    logic [31:0] rd;
    logic        er;
    logic        seen;
    logic [31:0] d [3];
    int          last_acc;
    int          acc;
    int          waited;
    int          r;
    logic [31:0] a;

    for (int i = 0; i < NW; i++) model_known[i] = 4'h0;

    // Reset values
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_state1", 32'(dbg_state1), 32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_req_ready", 32'(req_ready), 32'd1);

    // Store then load
    transact(32'h10, 32'hDEAD_BEEF, 4'b1111, 0, rd, er);
    transact(32'h10, 32'h0, 4'b0000, 0, rd, er);
    check_eq("load_0x10", rd, 32'hDEAD_BEEF);
    check_eq("load_0x10_err", 32'(er), 32'd0);

    // Byte strobes with read-first
    transact(32'h20, 32'h1122_3344, 4'b1111, 0, rd, er);
    transact(32'h20, 32'hAABB_CCDD, 4'b0101, 0, rd, er);
    check_eq("strobe_readfirst", rd, 32'h1122_3344);
    transact(32'h20, 32'h0, 4'b0000, 0, rd, er);
    check_eq("strobe_merge", rd, 32'h11BB_33DD);

    // Errors
    transact(32'h13, 32'h0, 4'b0000, 0, rd, er);
    check_eq("misalign_err", 32'(er), 32'd1);
    check_eq("misalign_rdata", rd, 32'd0);
    transact(32'h0, 32'h1234_5678, 4'b1111, 0, rd, er);
    transact(32'h800, 32'hFFFF_FFFF, 4'b1111, 0, rd, er);
    check_eq("range_err", 32'(er), 32'd1);
    transact(32'h0, 32'h0, 4'b0000, 0, rd, er);
    check_eq("range_nowrite", rd, 32'h1234_5678);

    // Backpressure for 5 cycles
    transact(32'h10, 32'h0, 4'b0000, 5, rd, er);
    check_eq("bp_load", rd, 32'hDEAD_BEEF);

    // Reset in the middle of WAIT after a store
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h55;
    req_wstrb = 4'b1111;
    model_mem[16]   = 32'h55;
    model_known[16] = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq("mid_state_wait", 32'(dbg_state), 32'(WAIT));
    #3;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check_eq("no_resp_after_rst", 32'(seen), 32'd0);
    transact(32'h40, 32'h0, 4'b0000, 0, rd, er);
    check_eq("store_survives_rst", rd, 32'h0000_0055);

    // Randomized traffic over a small window, with bad addresses mixed in
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      end else if (r == 1) begin
        a = (32'($urandom_range(1, 32'h1F_FFFF)) << 11) | (32'($urandom_range(0, 15)) << 2);
      end else begin
        a = 32'($urandom_range(0, 15)) << 2;
      end
      transact(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), rd, er);
    end

    // LATENCY=1 back-to-back: three stores then three loads, valid held high
    for (int k = 0; k < 3; k++) d[k] = $urandom;
    last_acc = 0;
    for (int k = 0; k < 6; k++) begin
      waited = 0;
      @(negedge clk);
      while (!req_ready1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check_eq("l1_ready", 32'(req_ready1), 32'd1);
      check_eq("l1_idle_valid", 32'(resp_valid1), 32'd0);
      req_valid1 = 1'b1;
      req_addr1  = 32'(4 * (k % 3));
      req_wdata1 = (k < 3) ? d[k] : 32'h0;
      req_wstrb1 = (k < 3) ? 4'b1111 : 4'b0000;
      @(posedge clk);
      acc = cyc;
      #1;
      check_eq("l1_valid_next", 32'(resp_valid1), 32'd1);
      check_eq("l1_err", 32'(resp_err1), 32'd0);
      if (k >= 3) check_eq("l1_rdata", resp_rdata1, d[k-3]);
      if (k > 0) check_eq("l1_interval", 32'(acc - last_acc), 32'd2);
      last_acc = acc;
    end
    req_valid1 = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
